// File: rtl/btn_press_scheduler_pkg.sv
// Shared types, button indices and the round-robin pick used by the press scheduler.
package btn_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned BTN_C        = 0;
    localparam int unsigned BTN_U        = 1;
    localparam int unsigned BTN_L        = 2;
    localparam int unsigned BTN_R        = 3;
    localparam int unsigned BTN_D        = 4;
    localparam int unsigned NBTN_DEFAULT = 5;
    localparam int unsigned LOCK_MIN     = 1;
    localparam int unsigned MAXBTN       = 32;

    // First set bit of pend searching circularly upward from ptr, over n buttons.
    function automatic int unsigned rr_select(input logic [MAXBTN-1:0] pend,
                                              input int unsigned ptr,
                                              input int unsigned n);
        int unsigned idx;
        logic        found;
        rr_select = 0;
        found     = 1'b0;
        for (int unsigned k = 0; k < MAXBTN; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (k < n) && pend[idx[4:0]]) begin
                rr_select = idx;
                found     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/btn_press_scheduler_sync.sv
// Multi-flop synchroniser for one raw button input.
module btn_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/btn_press_scheduler.sv
// Debounce by shared lockout: one arbitrated timer grants button edges round-robin
// and emits clean press/release pulses plus debounced levels.
module btn_press_scheduler
    import btn_pkg::*;
#(
    parameter int unsigned NBTN        = NBTN_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IDXW        = $clog2(NBTN)
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic [NBTN-1:0] btn_raw,
    input  logic [31:0]     m,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_pulse,
    output logic [NBTN-1:0] rel_pulse,
    output logic            busy,
    output logic [IDXW-1:0] grant_idx
);

    logic [NBTN-1:0] s;
    logic [NBTN-1:0] pend_c;
    logic [IDXW-1:0] sel_c;
    logic [IDXW-1:0] ptr_nxt_c;
    logic [NBTN-1:0] onehot_c;
    logic [31:0]     lock_len_c;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [31:0]     counter;

    for (genvar i = 0; i < NBTN; i++) begin : g_sync
        btn_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .CLOCK(CLOCK),
            .RESET(RESET),
            .d    (btn_raw[i]),
            .q    (s[i])
        );
    end

    // A pending event is any disagreement between the synchronised input and the clean level.
    assign pend_c     = s ^ btn_level;
    assign sel_c      = IDXW'(rr_select(MAXBTN'(pend_c), 32'(ptr), NBTN));
    assign ptr_nxt_c  = (sel_c == IDXW'(NBTN - 1)) ? '0 : sel_c + 1'b1;
    assign onehot_c   = NBTN'(1) << sel_c;
    assign lock_len_c = (m < 32'(LOCK_MIN)) ? 32'(LOCK_MIN) : m;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            btn_level <= '0;
            btn_pulse <= '0;
            rel_pulse <= '0;
            busy      <= 1'b0;
            grant_idx <= '0;
            ptr       <= '0;
            counter   <= '0;
        end else begin
            btn_pulse <= '0;
            rel_pulse <= '0;
            case (state)
                IDLE: begin
                    if (|pend_c) begin
                        btn_level <= btn_level ^ onehot_c;
                        btn_pulse <= onehot_c & ~btn_level;
                        rel_pulse <= onehot_c & btn_level;
                        grant_idx <= sel_c;
                        ptr       <= ptr_nxt_c;
                        counter   <= lock_len_c;
                        busy      <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                HOLD: begin
                    // Input changes are ignored here; they stay pending until IDLE.
                    if (counter == 32'd1) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    counter <= counter - 32'd1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_press_scheduler.sv
// Scoreboard bench: a timestamp-based model queues expected grants; a negedge monitor checks them.
module tb_btn_press_scheduler;

    localparam int unsigned NBTN = 5;
    localparam int unsigned SYNC = 2;
    localparam int unsigned IDXW = 3;

    typedef struct {
        logic [NBTN-1:0] pv;
        logic [NBTN-1:0] rv;
        int unsigned     idx;
        int unsigned     edge_n;
    } ev_t;

    logic            CLOCK;
    logic            RESET;
    logic [NBTN-1:0] btn_raw;
    logic [31:0]     m;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_pulse;
    logic [NBTN-1:0] rel_pulse;
    logic            busy;
    logic [IDXW-1:0] grant_idx;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    ev_t             sbq[$];
    logic [NBTN-1:0] hist[SYNC];
    logic [NBTN-1:0] mdl_lvl;
    int unsigned     mdl_ptr;
    int unsigned     cyc;
    int unsigned     free_at;
    int unsigned     busy_end;
    logic            exp_busy;

    btn_press_scheduler #(
        .NBTN       (NBTN),
        .SYNC_STAGES(SYNC),
        .IDXW       (IDXW)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .btn_raw  (btn_raw),
        .m        (m),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .rel_pulse(rel_pulse),
        .busy     (busy),
        .grant_idx(grant_idx)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: s is the raw input delayed SYNC edges; a grant is allowed once the
    // previous lockout plus one idle cycle has elapsed.
    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < SYNC; k++) hist[k] = '0;
            mdl_lvl  = '0;
            mdl_ptr  = 0;
            cyc      = 0;
            free_at  = 0;
            busy_end = 0;
            exp_busy = 1'b0;
            sbq.delete();
        end else begin
            logic [NBTN-1:0] pend;
            cyc++;
            pend = hist[SYNC-1] ^ mdl_lvl;
            if (cyc >= free_at && pend != '0) begin
                int unsigned     pick;
                int unsigned     len;
                logic [NBTN-1:0] oh;
                ev_t             e;
                pick = 0;
                for (int k = NBTN - 1; k >= 0; k--) begin
                    if (pend[(mdl_ptr + k) % NBTN]) pick = (mdl_ptr + k) % NBTN;
                end
                oh       = '0;
                oh[pick] = 1'b1;
                len      = (m == 0) ? 1 : m;
                e.pv     = mdl_lvl[pick] ? '0 : oh;
                e.rv     = mdl_lvl[pick] ? oh : '0;
                e.idx    = pick;
                e.edge_n = cyc;
                sbq.push_back(e);
                mdl_lvl  = mdl_lvl ^ oh;
                mdl_ptr  = (pick + 1) % NBTN;
                busy_end = cyc + len;
                free_at  = cyc + len + 1;
            end
            exp_busy = (cyc < busy_end);
            for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = btn_raw;
        end
    end

    always @(negedge CLOCK) begin
        if (!RESET) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("btn_level", 32'(btn_level), 32'(mdl_lvl));
            if ((btn_pulse | rel_pulse) != '0) begin
                if (sbq.size() != 0 && sbq[0].edge_n == cyc) begin
                    ev_t e;
                    e = sbq.pop_front();
                    chk("btn_pulse", 32'(btn_pulse), 32'(e.pv));
                    chk("rel_pulse", 32'(rel_pulse), 32'(e.rv));
                    chk("grant_idx", 32'(grant_idx), e.idx);
                end else begin
                    chk("unexpected_pulse", 32'(btn_pulse | rel_pulse), 32'd0);
                end
            end else if (sbq.size() != 0 && sbq[0].edge_n <= cyc) begin
                chk("missing_pulse", 32'(btn_pulse | rel_pulse), 32'(sbq[0].pv | sbq[0].rv));
                void'(sbq.pop_front());
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"}, 32'(btn_level), 32'd0);
        chk({tag, "_pulse"}, 32'(btn_pulse | rel_pulse), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant"}, 32'(grant_idx), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET   = 1'b1;
        btn_raw = '0;
        run(2);
        chk_all_zero("reset");
        RESET = 1'b0;
    endtask

    initial begin
        RESET   = 1'b1;
        btn_raw = '0;
        m       = 32'd0;

        // Single press with m=4
        do_reset();
        m       = 32'd4;
        btn_raw = 5'b00001;
        run(12);

        // Bounce on button 2 with m=8
        do_reset();
        m = 32'd8;
        foreach (btn_raw[i]) btn_raw[i] = 1'b0;
        btn_raw[2] = 1'b1; run(1);
        btn_raw[2] = 1'b0; run(1);
        btn_raw[2] = 1'b1; run(1);
        btn_raw[2] = 1'b0; run(1);
        btn_raw[2] = 1'b1;
        run(20);

        // Simultaneous presses, m=3
        do_reset();
        m       = 32'd3;
        btn_raw = 5'b00101;
        run(14);

        // Press then release of button 1, m=2
        do_reset();
        m       = 32'd2;
        btn_raw = 5'b00010;
        run(10);
        btn_raw = 5'b00000;
        run(10);

        // m=0 behaves as one cycle; m change during HOLD is ignored
        do_reset();
        m       = 32'd0;
        btn_raw = 5'b10000;
        run(8);
        m       = 32'd10;
        btn_raw = 5'b11000;
        run(6);
        m = 32'd2;
        run(14);

        // Asynchronous reset in the middle of a long HOLD
        do_reset();
        m       = 32'd20;
        btn_raw = 5'b01000;
        run(8);
        #2 RESET = 1'b1;
        #1 chk_all_zero("async_reset");
        run(2);
        RESET = 1'b0;
        run(10);

        // Randomised traffic
        do_reset();
        m = 32'd3;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLOCK);
            for (int b = 0; b < NBTN; b++) begin
                if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
            end
            if ($urandom_range(0, 49) == 0) m = 32'($urandom_range(0, 6));
        end
        run(80);
        chk("drain", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
